// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_ctrl
// Purpose  : 5-stage pipeline hazard unit: load-use / RAW stall, registered
//            EX operand-forward selects and HI/LO (MDU) busy interlock.
//            Define HAZ_FWD_EN to resolve ALU RAW hazards by forwarding;
//            without it RAW hazards stall until the producer reaches WB.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl #(
    parameter int unsigned MDU_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_mdu_start,
    input  logic       id_hilo_rd,
    input  logic [4:0] ex_reg_dest,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    output logic       stall,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       mdu_busy
);

    localparam logic [1:0] c_sel_rf    = 2'b00;
    localparam logic [1:0] c_sel_exmem = 2'b01;
    localparam logic [1:0] c_sel_memwb = 2'b10;
    localparam logic [3:0] c_mdu_lat   = 4'(MDU_LATENCY);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    mdu_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_valid_q, mem_valid_d;
    logic [4:0] mem_dest_q, mem_dest_d;

    logic ex_valid;
    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic ld_haz, mdu_haz, raw_haz;

    function automatic logic hit(input logic use_r, input logic tag_v,
                                 input logic [4:0] tag_d, input logic [4:0] r);
        return use_r && tag_v && (tag_d == r) && (r != 5'd0);
    endfunction

    // The WB stage carries no tag: the regfile writes before it is read.
    always_comb begin
        ex_valid    = ex_reg_write && (ex_reg_dest != 5'd0);
        mem_valid_d = ex_valid;
        mem_dest_d  = ex_reg_dest;
        ex_hit_a    = hit(id_use_rs, ex_valid, ex_reg_dest, id_rs);
        ex_hit_b    = hit(id_use_rt, ex_valid, ex_reg_dest, id_rt);
        mem_hit_a   = hit(id_use_rs, mem_valid_q, mem_dest_q, id_rs);
        mem_hit_b   = hit(id_use_rt, mem_valid_q, mem_dest_q, id_rt);
    end

    assign mdu_busy = (state_q == ST_BUSY);
    assign ld_haz   = id_valid && ex_mem_read && (ex_hit_a || ex_hit_b);
    assign mdu_haz  = id_valid && mdu_busy && (id_hilo_rd || id_mdu_start);

`ifdef HAZ_FWD_EN
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    assign raw_haz = 1'b0;

    // Youngest writer (EX/MEM) takes priority over the older MEM/WB copy.
    always_comb begin
        fwd_a_d = c_sel_rf;
        fwd_b_d = c_sel_rf;
        if (id_valid && !stall) begin
            if (ex_hit_a)       fwd_a_d = c_sel_exmem;
            else if (mem_hit_a) fwd_a_d = c_sel_memwb;
            if (ex_hit_b)       fwd_b_d = c_sel_exmem;
            else if (mem_hit_b) fwd_b_d = c_sel_memwb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= c_sel_rf;
            fwd_b_q <= c_sel_rf;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
`else
    assign raw_haz   = id_valid && (ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b);
    assign fwd_a_sel = c_sel_rf;
    assign fwd_b_sel = c_sel_rf;
`endif

    assign stall = ld_haz || mdu_haz || raw_haz;

    // A start refused by a stall is simply re-presented by ID next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (id_valid && id_mdu_start && !stall) begin
                    state_d = ST_BUSY;
                    cnt_d   = c_mdu_lat;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            mem_valid_q <= 1'b0;
            mem_dest_q  <= 5'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_dest_q  <= mem_dest_d;
        end
    end

endmodule
`default_nettype wire
